// File: rtl/hostsystem_mem_tester_if.sv
// Avalon-MM bus between the memory tester (master) and the on-chip memory slave.
// The master drives the request fields; the slave answers with stall and read data.
interface hostsystem_mem_tester_if #(
  parameter int ADDR_W = 13
);
  logic [ADDR_W-1:0] avm_address;
  logic [3:0]        avm_byteenable;
  logic              avm_chipselect;
  logic              avm_read;
  logic              avm_write;
  logic [31:0]       avm_writedata;
  logic              avm_waitrequest;
  logic [31:0]       avm_readdata;
  logic              avm_readdatavalid;

  modport master (
    output avm_address, avm_byteenable, avm_chipselect, avm_read, avm_write, avm_writedata,
    input  avm_waitrequest, avm_readdata, avm_readdatavalid
  );

  modport slave (
    input  avm_address, avm_byteenable, avm_chipselect, avm_read, avm_write, avm_writedata,
    output avm_waitrequest, avm_readdata, avm_readdatavalid
  );
endinterface

// File: rtl/hostsystem_mem_tester.sv
// Avalon-MM memory tester: fills a word range with an LFSR pattern, then reads it back
// with up to MAX_PEND reads in flight and counts mismatches against a second LFSR.
module hostsystem_mem_tester #(
  parameter int ADDR_W   = 13,
  parameter int MAX_PEND = 4,
  parameter int ERRC_W   = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base,
  input  logic [ADDR_W-2:0]   count,
  input  logic [1:0]          mode,
  input  logic [31:0]         seed,
  output logic                busy,
  output logic                done,
  output logic [ERRC_W-1:0]   err_count,
  output logic [ADDR_W-1:0]   first_err_addr,
  hostsystem_mem_tester_if.master avm
);
  localparam int CNT_W  = ADDR_W - 1;
  localparam int PEND_W = 4;

  typedef enum logic [1:0] {ST_IDLE, ST_FILL, ST_CHECK, ST_FINISH} state_t;

  state_t              state_reg, state_next;
  logic                mode_chk_reg;
  logic [CNT_W-1:0]    count_reg, idx_reg, rcv_reg, last_idx;
  logic [ADDR_W-1:0]   base_reg, addr_reg, chk_addr_reg, first_err_reg, base_aligned;
  logic [31:0]         seed_reg, gen_reg, exp_reg, seed_fixed;
  logic [PEND_W-1:0]   pend_reg;
  logic [ERRC_W-1:0]   err_reg;
  logic                start_ok, wr_acc, rd_req, rd_acc, ret, mismatch, enter_check;

  function automatic logic [31:0] lfsr_step(input logic [31:0] cur);
    return {cur[30:0], cur[31] ^ cur[21] ^ cur[1] ^ cur[0]};
  endfunction

  assign base_aligned = base & ~ADDR_W'(3);
  assign seed_fixed   = (seed == 32'h0) ? 32'h1 : seed;
  assign last_idx     = count_reg - CNT_W'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_reg <= ST_IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next  = state_reg;
    start_ok    = start && (mode != 2'b00) && (count != '0);
    wr_acc      = (state_reg == ST_FILL) && !avm.avm_waitrequest;
    // Issue stays asserted under stall: idx only moves on accept, pending only falls.
    rd_req      = (state_reg == ST_CHECK) && (idx_reg != count_reg) &&
                  (pend_reg < PEND_W'(MAX_PEND));
    rd_acc      = rd_req && !avm.avm_waitrequest;
    ret         = (state_reg == ST_CHECK) && avm.avm_readdatavalid && (pend_reg != '0);
    mismatch    = ret && (avm.avm_readdata != exp_reg);
    case (state_reg)
      ST_IDLE: begin
        if (start_ok)   state_next = mode[0] ? ST_FILL : ST_CHECK;
        else if (start) state_next = ST_FINISH;
      end
      ST_FILL: begin
        if (wr_acc && (idx_reg == last_idx))
          state_next = mode_chk_reg ? ST_CHECK : ST_FINISH;
      end
      ST_CHECK: begin
        if (ret && (rcv_reg == last_idx)) state_next = ST_FINISH;
      end
      default: state_next = ST_IDLE;
    endcase
    enter_check = (state_next == ST_CHECK) && (state_reg != ST_CHECK);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_chk_reg <= 1'b0;
      count_reg    <= '0;
      base_reg     <= '0;
      seed_reg     <= '0;
      addr_reg     <= '0;
      gen_reg      <= '0;
      exp_reg      <= '0;
      idx_reg      <= '0;
      rcv_reg      <= '0;
      chk_addr_reg <= '0;
      pend_reg     <= '0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start_ok) begin
            mode_chk_reg <= mode[1];
            count_reg    <= count;
            base_reg     <= base_aligned;
            seed_reg     <= seed_fixed;
            addr_reg     <= base_aligned;
            gen_reg      <= seed_fixed;
            exp_reg      <= seed_fixed;
            idx_reg      <= '0;
            rcv_reg      <= '0;
            chk_addr_reg <= base_aligned;
            pend_reg     <= '0;
          end
        end
        ST_FILL: begin
          // Read-back restarts both the address walk and the pattern from the seed.
          if (state_next == ST_CHECK) begin
            idx_reg      <= '0;
            addr_reg     <= base_reg;
            gen_reg      <= seed_reg;
            exp_reg      <= seed_reg;
            chk_addr_reg <= base_reg;
          end else if (wr_acc) begin
            idx_reg  <= idx_reg + CNT_W'(1);
            addr_reg <= addr_reg + ADDR_W'(4);
            gen_reg  <= lfsr_step(gen_reg);
          end
        end
        ST_CHECK: begin
          if (rd_acc) begin
            idx_reg  <= idx_reg + CNT_W'(1);
            addr_reg <= addr_reg + ADDR_W'(4);
          end
          if (ret) begin
            exp_reg      <= lfsr_step(exp_reg);
            rcv_reg      <= rcv_reg + CNT_W'(1);
            chk_addr_reg <= chk_addr_reg + ADDR_W'(4);
          end
          if (rd_acc && !ret)      pend_reg <= pend_reg + PEND_W'(1);
          else if (!rd_acc && ret) pend_reg <= pend_reg - PEND_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_reg       <= '0;
      first_err_reg <= '0;
    end else if (enter_check) begin
      err_reg       <= '0;
      first_err_reg <= '0;
    end else if (mismatch) begin
      if (err_reg == '0) first_err_reg <= chk_addr_reg;
      if (err_reg != '1) err_reg <= err_reg + ERRC_W'(1);
    end
  end

  assign busy               = (state_reg != ST_IDLE);
  assign done               = (state_reg == ST_FINISH);
  assign err_count          = err_reg;
  assign first_err_addr     = first_err_reg;
  assign avm.avm_write      = (state_reg == ST_FILL);
  assign avm.avm_read       = rd_req;
  assign avm.avm_chipselect = avm.avm_write | rd_req;
  assign avm.avm_byteenable = 4'b1111;
  assign avm.avm_address    = addr_reg;
  assign avm.avm_writedata  = gen_reg;
endmodule

// File: tb/tb_hostsystem_mem_tester.sv
// Directed bench for hostsystem_mem_tester with a behavioural memory slave that can
// stall, delay read returns and corrupt chosen words.
module tb_hostsystem_mem_tester;
  localparam int ADDR_W   = 13;
  localparam int MAX_PEND = 4;
  localparam int ERRC_W   = 16;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic               start = 1'b0;
  logic [ADDR_W-1:0]  base = '0;
  logic [ADDR_W-2:0]  count = '0;
  logic [1:0]         mode = '0;
  logic [31:0]        seed = '0;
  logic               busy, done;
  logic [ERRC_W-1:0]  err_count;
  logic [ADDR_W-1:0]  first_err_addr;

  hostsystem_mem_tester_if #(.ADDR_W(ADDR_W)) avm_if ();

  hostsystem_mem_tester #(.ADDR_W(ADDR_W), .MAX_PEND(MAX_PEND), .ERRC_W(ERRC_W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .base(base), .count(count),
    .mode(mode), .seed(seed), .busy(busy), .done(done), .err_count(err_count),
    .first_err_addr(first_err_addr), .avm(avm_if)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests_run = 0;
  int tests_failed = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- memory slave + bus monitor ----------------
  typedef struct packed {
    int          due;
    logic [31:0] data;
  } ret_t;

  logic [31:0] mem [0:2047];
  ret_t        rq[$];
  bit          stall_en = 1'b0;
  bit          corrupt_en = 1'b0;
  int          max_dly = 1;
  int          out_cnt = 0, max_out = 0, stab_err = 0, cs_err = 0, cs_cnt = 0, last_due = 0;
  logic        prev_stalled = 1'b0;
  logic [46:0] prev_req = '0, cur_req;
  logic        w;
  logic [31:0] rd_word;
  int          due;
  logic [ADDR_W-1:0] wr_addr_log[$];
  logic [31:0]       wr_data_log[$];
  int                wr_cyc_log[$];

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = 32'h0;
    avm_if.avm_waitrequest   = 1'b0;
    avm_if.avm_readdata      = 32'h0;
    avm_if.avm_readdatavalid = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        rq.delete();
        avm_if.avm_readdatavalid = 1'b0;
        avm_if.avm_waitrequest   = 1'b0;
        out_cnt = 0;
        last_due = 0;
        prev_stalled = 1'b0;
      end else begin
        w = stall_en ? 1'($urandom_range(0, 1)) : 1'b0;
        avm_if.avm_waitrequest = w;
        cur_req = {avm_if.avm_read, avm_if.avm_write, avm_if.avm_address, avm_if.avm_writedata};
        if (prev_stalled && (cur_req !== prev_req)) stab_err++;
        prev_stalled = (avm_if.avm_read | avm_if.avm_write) & w;
        prev_req = cur_req;
        if (avm_if.avm_chipselect !== (avm_if.avm_read | avm_if.avm_write)) cs_err++;
        if (avm_if.avm_chipselect === 1'b1) cs_cnt++;
        if (rq.size() > 0 && rq[0].due <= cyc) begin
          avm_if.avm_readdata      = rq[0].data;
          avm_if.avm_readdatavalid = 1'b1;
          void'(rq.pop_front());
          out_cnt--;
        end else begin
          avm_if.avm_readdata      = 32'h0;
          avm_if.avm_readdatavalid = 1'b0;
        end
        if (!w && avm_if.avm_write) begin
          mem[avm_if.avm_address[12:2]] = avm_if.avm_writedata;
          wr_addr_log.push_back(avm_if.avm_address);
          wr_data_log.push_back(avm_if.avm_writedata);
          wr_cyc_log.push_back(cyc);
        end
        if (!w && avm_if.avm_read) begin
          rd_word = mem[avm_if.avm_address[12:2]];
          if (corrupt_en && (avm_if.avm_address == 13'h114 || avm_if.avm_address == 13'h124))
            rd_word = rd_word ^ 32'h0000_0100;
          due = cyc + $urandom_range(1, max_dly);
          if (due <= last_due) due = last_due + 1;
          last_due = due;
          rq.push_back('{due: due, data: rd_word});
          out_cnt++;
        end
        if (out_cnt > max_out) max_out = out_cnt;
      end
    end
  end

  // ---------------- run helpers ----------------
  int start_cyc, done_cyc;

  task automatic start_run(input logic [ADDR_W-1:0] b, input logic [ADDR_W-2:0] c,
                           input logic [1:0] m, input logic [31:0] s);
    @(posedge clk); #1;
    base = b; count = c; mode = m; seed = s; start = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq({tag, "_done"}, 32'(done), 32'h1);
    done_cyc = cyc;
    $display("[TB] run %s mode=%0d base=0x%0h count=%0d: done %0d cycles after start, err_count=%0d first_err_addr=0x%0h",
             tag, mode, base, count, done_cyc - start_cyc, err_count, first_err_addr);
  endtask

  function automatic logic [31:0] lfsr_model(input logic [31:0] cur);
    return {cur[30:0], cur[31] ^ cur[21] ^ cur[1] ^ cur[0]};
  endfunction

  initial begin : watchdog
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    logic [31:0] t1_data [4];
    logic [12:0] t5_addr [4];
    logic [31:0] model;
    int bad;
    int cs_snap;
    t1_data = '{32'h1, 32'h3, 32'h6, 32'hD};
    t5_addr = '{13'h1FF8, 13'h1FFC, 13'h0000, 13'h0004};

    // reset state
    #22;
    check_eq("rst_busy", 32'(busy), 32'h0);
    check_eq("rst_done", 32'(done), 32'h0);
    check_eq("rst_err_count", 32'(err_count), 32'h0);
    check_eq("rst_first_err", 32'(first_err_addr), 32'h0);
    check_eq("rst_cs", 32'(avm_if.avm_chipselect), 32'h0);
    check_eq("rst_addr", 32'(avm_if.avm_address), 32'h0);
    check_eq("rst_wdata", avm_if.avm_writedata, 32'h0);
    @(posedge clk); #1;
    reset_n = 1'b1;

    // 1: plain fill of four words
    wr_addr_log.delete(); wr_data_log.delete(); wr_cyc_log.delete();
    start_run(13'h0, 12'd4, 2'b01, 32'h1);
    check_eq("t1_busy", 32'(busy), 32'h1);
    wait_done("t1", 50);
    check_eq("t1_nwrites", wr_addr_log.size(), 32'd4);
    if (wr_addr_log.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        check_eq($sformatf("t1_addr%0d", i), 32'(wr_addr_log[i]), 32'(i * 4));
        check_eq($sformatf("t1_data%0d", i), wr_data_log[i], t1_data[i]);
        check_eq($sformatf("t1_cyc%0d", i), wr_cyc_log[i], start_cyc + 1 + i);
      end
    end
    check_eq("t1_done_cyc", done_cyc, start_cyc + 5);

    // 2: full memory fill and check, latency-1 slave
    max_out = 0;
    start_run(13'h0, 12'd2048, 2'b11, 32'h0000_ACE1);
    wait_done("t2", 5000);
    check_eq("t2_err_count", 32'(err_count), 32'h0);
    check_eq("t2_word0", mem[0], 32'h0000_ACE1);
    check_eq("t2_word1", mem[1], 32'h0001_59C3);
    model = 32'h0000_ACE1;
    bad = 0;
    for (int i = 0; i < 2048; i++) begin
      if (mem[i] !== model) bad++;
      model = lfsr_model(model);
    end
    check_eq("t2_mem_pattern", bad, 0);
    @(posedge clk); #1;
    check_eq("t2_busy_after", 32'(busy), 32'h0);
    check_eq("t2_done_pulse", 32'(done), 32'h0);
    check_eq("t2_max_pending", 32'(max_out <= MAX_PEND), 32'h1);

    // 3: fill then corrupted check-only pass at base 0x100
    start_run(13'h100, 12'd16, 2'b01, 32'h0BAD_F00D);
    wait_done("t3_fill", 100);
    corrupt_en = 1'b1;
    start_run(13'h100, 12'd16, 2'b10, 32'h0BAD_F00D);
    wait_done("t3_check", 200);
    check_eq("t3_err_count", 32'(err_count), 32'd2);
    check_eq("t3_first_err", 32'(first_err_addr), 32'h114);

    // 4: random stalls and return delays, same corruption
    stall_en = 1'b1; max_dly = 6; max_out = 0; stab_err = 0;
    start_run(13'h100, 12'd32, 2'b11, 32'hDEAD_BEEF);
    wait_done("t4", 2000);
    check_eq("t4_err_count", 32'(err_count), 32'd2);
    check_eq("t4_first_err", 32'(first_err_addr), 32'h114);
    check_eq("t4_word0", mem[13'h100 >> 2], 32'hDEAD_BEEF);
    check_eq("t4_stable_under_stall", stab_err, 0);
    check_eq("t4_max_pending", 32'(max_out <= MAX_PEND), 32'h1);
    stall_en = 1'b0; max_dly = 1; corrupt_en = 1'b0;

    // 5: address wrap, then zero-count run
    wr_addr_log.delete(); wr_data_log.delete(); wr_cyc_log.delete();
    start_run(13'h1FF8, 12'd4, 2'b01, 32'h1);
    wait_done("t5_wrap", 50);
    check_eq("t5_nwrites", wr_addr_log.size(), 32'd4);
    if (wr_addr_log.size() == 4) begin
      for (int i = 0; i < 4; i++)
        check_eq($sformatf("t5_addr%0d", i), 32'(wr_addr_log[i]), 32'(t5_addr[i]));
    end
    cs_snap = cs_cnt;
    start_run(13'h0, 12'd0, 2'b01, 32'h1);
    wait_done("t5_zero", 10);
    check_eq("t5_zero_done_cyc", done_cyc, start_cyc + 1);
    @(posedge clk); #1;
    check_eq("t5_zero_no_cs", cs_cnt, cs_snap);
    check_eq("t5_err_kept", 32'(err_count), 32'd2);

    // 6: reset in the middle of a fill
    start_run(13'h0, 12'd100, 2'b01, 32'h7);
    repeat (4) begin @(posedge clk); #1; end
    check_eq("t6_mid_fill_write", 32'(avm_if.avm_write), 32'h1);
    reset_n = 1'b0;
    #1;
    check_eq("t6_rst_write", 32'(avm_if.avm_write), 32'h0);
    check_eq("t6_rst_cs", 32'(avm_if.avm_chipselect), 32'h0);
    check_eq("t6_rst_busy", 32'(busy), 32'h0);
    check_eq("t6_rst_addr", 32'(avm_if.avm_address), 32'h0);
    check_eq("t6_rst_wdata", avm_if.avm_writedata, 32'h0);
    check_eq("t6_rst_err", 32'(err_count), 32'h0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    start_run(13'h200, 12'd8, 2'b11, 32'h5);
    wait_done("t6_rerun", 200);
    check_eq("t6_rerun_err", 32'(err_count), 32'h0);
    check_eq("t6_rerun_word0", mem[13'h200 >> 2], 32'h5);

    check_eq("cs_matches_rw", cs_err, 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
